ascii_case_stream: RTL and testbench
====================================

// Module: ascii_case_stream
// PURPOSE
//  Streaming ASCII case converter: LANES bytes per beat, valid/ready in and out, one registered
//  stage plus skid buffer. Mode (pass/upper/lower/toggle) is latched per frame. Sits between a
//  byte-stream source (UART/FIFO) and text consumers; generalises the single-byte to-upper gate.
// PARAMETERS
//  LANES    4   bytes per beat; data width = 8*LANES; lane 0 = bits [7:0] = first byte
//  CNT_W    16  width of conv_count (used only with CASE_STATS_EN)
// PORTS
//  clk         in   1          clock, rising edge
//  rst         in   1          asynchronous, active-high reset
//  mode        in   2          00 pass, 01 upper, 10 lower, 11 toggle; sampled on first beat of frame
//  in_valid    in   1          input beat valid
//  in_ready    out  1          input beat accepted when in_valid & in_ready
//  in_data     in   8*LANES    input bytes
//  in_last     in   1          marks final beat of frame
//  out_valid   out  1          output beat valid
//  out_ready   in   1          downstream accepts when out_valid & out_ready
//  out_data    out  8*LANES    converted bytes
//  out_last    out  1          in_last carried with its beat
//  busy        out  1          1 while a frame is open (state ACTIVE) or any beat is buffered
//  stat_clr    in   1          [CASE_STATS_EN only] synchronous clear of conv_count
//  conv_count  out  CNT_W      [CASE_STATS_EN only] bytes whose value was changed, saturating
// BEHAVIOUR
//  - Reset (async, rst=1): out_valid=0, out_data=0, out_last=0, in_ready=0 while rst high,
//    busy=0, state=IDLE, latched mode=00, both buffer slots empty, conv_count=0.
//    in_ready=1 from first clk edge after rst deasserts. Reset mid-frame discards all beats.
//  - Per-byte rule: letter = 0x41..0x5A or 0x61..0x7A only; all other bytes (incl. bit7=1,
//    0x40, 0x5B..0x60, 0x7B..0x7F) pass unchanged. upper: clear bit5 of lowercase letters;
//    lower: set bit5 of uppercase letters; toggle: invert bit5 of any letter; pass: no change.
//    Lanes converted independently; conversion applied on input acceptance.
//  - FSM: IDLE -> on accepted beat: latch mode; go ACTIVE unless in_last (stay IDLE).
//    ACTIVE -> uses latched mode; mode input ignored; accepted beat with in_last -> IDLE.
//    First-beat conversion uses the live mode input (same value latched).
//  - Buffering: output register (OR) + skid register (SK). Latency 1 cycle: beat accepted at
//    edge N appears on out_data after edge N with out_valid=1.
//    in_ready = !SK_full (registered). Accept with OR empty or OR draining -> write OR.
//    Accept while OR full and not draining -> write SK. OR drains -> SK (if full) moves to OR.
//    Simultaneous accept + drain with SK full is impossible (in_ready=0).
//    Full throughput (1 beat/clk) with out_ready held 1; order strictly preserved.
//  - out_data/out_last stable while out_valid=1 and out_ready=0.
//  - in_data/in_last ignored when in_valid=0 or in_ready=0; no X propagation into OR/SK.
// CONFIGURATION
//  CASE_STATS_EN defined: stat_clr and conv_count ports exist. On each output handshake,
//    conv_count += number of lanes whose out byte differs from its original input byte;
//    saturates at 2^CNT_W-1. stat_clr=1 forces 0 that cycle (clear wins over same-cycle add).
//  CASE_STATS_EN undefined: ports absent, no counter logic; datapath behaviour identical.
// TESTING
//  1 LANES=4, mode=01, beat "ab1Z" (0x5A,0x31,0x62,0x61), last=1, out_ready=1 -> next cycle
//    out_data=0x5A314241, out_last=1; busy back to 0 one cycle later.
//  2 mode=10 on beat0 of 3-beat frame, mode=01 during beats 1-2, data "HELO" each beat ->
//    all three outputs 0x6F6C6568 ("helo"); 4th frame with mode=01 -> uppercase.
//  3 Boundary bytes 0x40,0x5B,0x60,0x7B and 0xE1 under mode=11 -> unchanged; 0x41->0x61,
//    0x7A->0x5A.
//  4 Backpressure: stream 6 beats, out_ready=0 for 4 cycles -> in_ready drops after 2 accepted,
//    out_data held stable; release -> all 6 delivered in order, no loss/duplication.
//  5 rst pulse mid-frame with OR and SK full -> out_valid=0, busy=0 immediately (async); next
//    frame's mode latched fresh and converts correctly.
//  6 CASE_STATS_EN: 3 beats "aBc1" mode=01 -> conv_count=6; stat_clr with a concurrent beat ->
//    0; CNT_W=4 with 20 changed bytes -> saturates at 15.

Source files
------------

// File: rtl/ascii_case_stream.sv
// ascii_case_stream: streaming ASCII case converter, LANES bytes per beat.
// Mode (pass/upper/lower/toggle) is latched on the first beat of each frame.
// Datapath: one output register (OR) plus a skid register (SK) for full
// throughput with registered in_ready.
// Optional feature macro: CASE_STATS_EN adds stat_clr / conv_count, a
// saturating count of bytes whose value was changed by the conversion.
module ascii_case_stream #(
  parameter int LANES = 4,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           mode,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [8*LANES-1:0]   in_data,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [8*LANES-1:0]   out_data,
  output logic                 out_last,
  output logic                 busy
`ifdef CASE_STATS_EN
  ,
  input  logic                 stat_clr,
  output logic [CNT_W-1:0]     conv_count
`endif
);

  localparam int DW = 8 * LANES;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      mode_q, mode_d;
  logic            or_valid_q, or_valid_d;
  logic [DW-1:0]   or_data_q, or_data_d;
  logic            or_last_q, or_last_d;
  logic            sk_valid_q, sk_valid_d;
  logic [DW-1:0]   sk_data_q, sk_data_d;
  logic            sk_last_q, sk_last_d;
  logic            in_ready_q, in_ready_d;
  logic            busy_q, busy_d;

  logic            accept_s;
  logic            drain_s;
  logic [1:0]      eff_mode_s;
  logic [DW-1:0]   conv_data_s;

  // Convert one byte; only 'A'..'Z' and 'a'..'z' are letters.
  function automatic logic [7:0] conv_byte(input logic [7:0] b, input logic [1:0] m);
    logic [7:0] r;
    logic       is_up;
    logic       is_lo;
    is_up = (b >= 8'h41) && (b <= 8'h5A);
    is_lo = (b >= 8'h61) && (b <= 8'h7A);
    r     = b;
    case (m)
      2'b00: r = b;
      2'b01: begin
        if (is_lo) r = b & 8'hDF;
        else       r = b;
      end
      2'b10: begin
        if (is_up) r = b | 8'h20;
        else       r = b;
      end
      2'b11: begin
        if (is_up || is_lo) r = b ^ 8'h20;
        else                r = b;
      end
      default: r = b;
    endcase
    return r;
  endfunction

  // Convert all lanes of a beat independently.
  function automatic logic [DW-1:0] conv_beat(input logic [DW-1:0] d, input logic [1:0] m);
    logic [DW-1:0] r;
    r = '0;
    for (int i = 0; i < LANES; i++) begin
      r[8*i +: 8] = conv_byte(d[8*i +: 8], m);
    end
    return r;
  endfunction

  assign accept_s    = in_valid & in_ready_q;
  assign drain_s     = or_valid_q & out_ready;
  assign conv_data_s = conv_beat(in_data, eff_mode_s);

  assign in_ready  = in_ready_q;
  assign out_valid = or_valid_q;
  assign out_data  = or_data_q;
  assign out_last  = or_last_q;
  assign busy      = busy_q;

`ifdef CASE_STATS_EN
  localparam int PC_W  = $clog2(LANES + 1);
  localparam int SUM_W = CNT_W + PC_W;

  logic [LANES-1:0] chg_s;
  logic [LANES-1:0] or_chg_q, or_chg_d;
  logic [LANES-1:0] sk_chg_q, sk_chg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SUM_W-1:0] sum_s;

  // Number of set bits in a lane-changed mask.
  function automatic logic [PC_W-1:0] popcount(input logic [LANES-1:0] m);
    logic [PC_W-1:0] r;
    r = '0;
    for (int i = 0; i < LANES; i++) begin
      r = r + PC_W'(m[i]);
    end
    return r;
  endfunction

  // Flag lanes whose converted byte differs from the original input byte.
  always_comb begin
    chg_s = '0;
    for (int i = 0; i < LANES; i++) begin
      chg_s[i] = (conv_data_s[8*i +: 8] != in_data[8*i +: 8]);
    end
  end

  // Saturating changed-byte counter; a clear beats a same-cycle add.
  always_comb begin
    cnt_d = cnt_q;
    sum_s = SUM_W'(cnt_q) + SUM_W'(popcount(or_chg_q));
    if (stat_clr) begin
      cnt_d = '0;
    end else if (drain_s) begin
      if (sum_s > SUM_W'({CNT_W{1'b1}})) cnt_d = {CNT_W{1'b1}};
      else                               cnt_d = sum_s[CNT_W-1:0];
    end else begin
      cnt_d = cnt_q;
    end
  end

  assign conv_count = cnt_q;
`endif

  // Frame FSM: latch mode on the first beat, pick the mode used for conversion.
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    eff_mode_s = mode_q;
    case (state_q)
      IDLE: begin
        eff_mode_s = mode;
        if (accept_s) begin
          mode_d = mode;
          if (in_last) state_d = IDLE;
          else         state_d = ACTIVE;
        end else begin
          state_d = IDLE;
        end
      end
      ACTIVE: begin
        if (accept_s && in_last) state_d = IDLE;
        else                     state_d = ACTIVE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // OR/SK buffer steering: fill OR first, overflow into SK, refill OR from SK.
  always_comb begin
    or_valid_d = or_valid_q;
    or_data_d  = or_data_q;
    or_last_d  = or_last_q;
    sk_valid_d = sk_valid_q;
    sk_data_d  = sk_data_q;
    sk_last_d  = sk_last_q;
`ifdef CASE_STATS_EN
    or_chg_d   = or_chg_q;
    sk_chg_d   = sk_chg_q;
`endif
    if (drain_s) begin
      if (sk_valid_q) begin
        // SK full implies in_ready was low, so no accept can coincide.
        or_valid_d = 1'b1;
        or_data_d  = sk_data_q;
        or_last_d  = sk_last_q;
        sk_valid_d = 1'b0;
`ifdef CASE_STATS_EN
        or_chg_d   = sk_chg_q;
`endif
      end else if (accept_s) begin
        or_valid_d = 1'b1;
        or_data_d  = conv_data_s;
        or_last_d  = in_last;
`ifdef CASE_STATS_EN
        or_chg_d   = chg_s;
`endif
      end else begin
        or_valid_d = 1'b0;
      end
    end else begin
      if (accept_s && or_valid_q) begin
        sk_valid_d = 1'b1;
        sk_data_d  = conv_data_s;
        sk_last_d  = in_last;
`ifdef CASE_STATS_EN
        sk_chg_d   = chg_s;
`endif
      end else if (accept_s) begin
        or_valid_d = 1'b1;
        or_data_d  = conv_data_s;
        or_last_d  = in_last;
`ifdef CASE_STATS_EN
        or_chg_d   = chg_s;
`endif
      end else begin
        or_valid_d = or_valid_q;
      end
    end
    in_ready_d = ~sk_valid_d;
    busy_d     = (state_d == ACTIVE) | or_valid_d | sk_valid_d;
  end

  // State, buffer and handshake registers; reset discards any buffered beats.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      mode_q     <= 2'b00;
      or_valid_q <= 1'b0;
      or_data_q  <= '0;
      or_last_q  <= 1'b0;
      sk_valid_q <= 1'b0;
      sk_data_q  <= '0;
      sk_last_q  <= 1'b0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
`ifdef CASE_STATS_EN
      or_chg_q   <= '0;
      sk_chg_q   <= '0;
      cnt_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      or_valid_q <= or_valid_d;
      or_data_q  <= or_data_d;
      or_last_q  <= or_last_d;
      sk_valid_q <= sk_valid_d;
      sk_data_q  <= sk_data_d;
      sk_last_q  <= sk_last_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
`ifdef CASE_STATS_EN
      or_chg_q   <= or_chg_d;
      sk_chg_q   <= sk_chg_d;
      cnt_q      <= cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_ascii_case_stream.sv
// Self-checking bench for ascii_case_stream: a character-level reference
// model plus a queue scoreboard, with directed vectors and literal checks.
module tb_ascii_case_stream;

  localparam int LANES = 4;
`ifdef CASE_STATS_EN
  localparam int CNT_W = 4;
`else
  localparam int CNT_W = 16;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  mode = 2'b00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = 32'h0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic        out_last;
  logic        busy;
`ifdef CASE_STATS_EN
  logic             stat_clr = 1'b0;
  logic [CNT_W-1:0] conv_count;
`endif

  ascii_case_stream #(.LANES(LANES), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .mode(mode),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy)
`ifdef CASE_STATS_EN
    , .stat_clr(stat_clr), .conv_count(conv_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic        l;
  } beat_t;

  beat_t exp_q[$];
  int    total = 0;
  int    bad = 0;
  int    acc_cnt = 0;
  int    dlv_cnt = 0;
  bit    m_in_frame = 1'b0;
  logic [1:0] m_mode = 2'b00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Reference: treat each byte as a character and shift case by 32.
  function automatic logic [7:0] ref_char(input logic [7:0] c, input logic [1:0] m);
    bit up = (c >= "A") && (c <= "Z");
    bit lo = (c >= "a") && (c <= "z");
    if (m == 2'd1 && lo) return c - 8'd32;
    if (m == 2'd2 && up) return c + 8'd32;
    if (m == 2'd3 && up) return c + 8'd32;
    if (m == 2'd3 && lo) return c - 8'd32;
    return c;
  endfunction

  function automatic logic [31:0] ref_beat(input logic [31:0] d, input logic [1:0] m);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = ref_char(d[8*i +: 8], m);
    return r;
  endfunction

  // Monitor / compare process on the falling edge.
  initial begin : monitor
    beat_t       e;
    bit          hold_v;
    logic [31:0] hold_d;
    logic        hold_l;
    logic [1:0]  use_m;
    hold_v = 1'b0;
    hold_d = 32'h0;
    hold_l = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        m_in_frame = 1'b0;
        hold_v = 1'b0;
      end else begin
        if (hold_v) begin
          chk("hold_valid", {31'h0, out_valid}, 32'h1);
          chk("hold_data", out_data, hold_d);
          chk("hold_last", {31'h0, out_last}, {31'h0, hold_l});
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_out", 32'h1, 32'h0);
          end else begin
            e = exp_q.pop_front();
            chk("out_data", out_data, e.d);
            chk("out_last", {31'h0, out_last}, {31'h0, e.l});
            dlv_cnt++;
          end
        end
        hold_v = out_valid && !out_ready;
        hold_d = out_data;
        hold_l = out_last;
        if (in_valid && in_ready) begin
          use_m = m_in_frame ? m_mode : mode;
          if (!m_in_frame) m_mode = mode;
          e.d = ref_beat(in_data, use_m);
          e.l = in_last;
          exp_q.push_back(e);
          m_in_frame = !in_last;
          acc_cnt++;
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic send(input logic [31:0] d, input logic l, input logic [1:0] m);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    mode     = m;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) chk("send_timeout", 32'h0, 32'h1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 32'hDEADBEEF;
    in_last  = 1'b1;
    mode     = 2'b11;
  endtask

  task automatic drain_wait();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 50) begin
      n++;
      @(posedge clk);
      #1;
    end
    chk("drain_done", exp_q.size(), 32'h0);
  endtask

  initial begin : stim
    int acc0;
    int dlv0;
    int n;
    logic [7:0] b0, b1, b2, b3;

    // Reset state
    #2;
    chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_out_last", {31'h0, out_last}, 32'h0);
    chk("rst_in_ready", {31'h0, in_ready}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("in_ready_after_rst", {31'h0, in_ready}, 32'h1);

    // 1: single-beat frame to upper
    out_ready = 1'b1;
    send(32'h5A316261, 1'b1, 2'b01);
    chk("t1_valid", {31'h0, out_valid}, 32'h1);
    chk("t1_data", out_data, 32'h5A314241);
    chk("t1_last", {31'h0, out_last}, 32'h1);
    chk("t1_busy", {31'h0, busy}, 32'h1);
    @(posedge clk);
    #1;
    chk("t1_busy_clr", {31'h0, busy}, 32'h0);
    chk("t1_valid_clr", {31'h0, out_valid}, 32'h0);

    // 2: mode latched on beat 0, ignored afterwards
    send(32'h4F4C4548, 1'b0, 2'b10);
    chk("t2_b0", out_data, 32'h6F6C6568);
    send(32'h4F4C4548, 1'b0, 2'b01);
    chk("t2_b1", out_data, 32'h6F6C6568);
    send(32'h4F4C4548, 1'b1, 2'b01);
    chk("t2_b2", out_data, 32'h6F6C6568);
    send(32'h4F4C4548, 1'b1, 2'b01);
    chk("t2_f4", out_data, 32'h4F4C4548);

    // 3: boundary bytes under toggle
    send(32'h7B605B40, 1'b0, 2'b11);
    chk("t3_nonletters", out_data, 32'h7B605B40);
    send(32'h007A41E1, 1'b1, 2'b11);
    chk("t3_letters", out_data, 32'h005A61E1);
    drain_wait();

    // 4: backpressure with 6 beats
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    acc0 = acc_cnt;
    dlv0 = dlv_cnt;
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          b3 = 8'h61 + 8'(i);
          b2 = 8'h41 + 8'(i);
          b1 = 8'h30 + 8'(i);
          b0 = 8'h7A - 8'(i);
          send({b3, b2, b1, b0}, (i == 5), (i == 0) ? 2'b01 : 2'b10);
        end
      end
      begin
        repeat (4) @(posedge clk);
        #1;
        chk("t4_in_ready_low", {31'h0, in_ready}, 32'h0);
        chk("t4_accepted", acc_cnt - acc0, 32'd2);
        chk("t4_first_beat", out_data, 32'h4141305A);
        out_ready = 1'b1;
      end
    join
    n = 0;
    while ((dlv_cnt - dlv0) < 6 && n < 30) begin
      n++;
      @(negedge clk);
    end
    chk("t4_delivered", dlv_cnt - dlv0, 32'd6);
    drain_wait();

    // 5: reset mid-frame with OR and SK full
    out_ready = 1'b0;
    send(32'h41424344, 1'b0, 2'b10);
    send(32'h45464748, 1'b0, 2'b10);
    chk("t5_sk_full", {31'h0, in_ready}, 32'h0);
    #2;
    rst = 1'b1;
    #1;
    chk("t5_rst_valid", {31'h0, out_valid}, 32'h0);
    chk("t5_rst_busy", {31'h0, busy}, 32'h0);
    chk("t5_rst_in_ready", {31'h0, in_ready}, 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("t5_in_ready_back", {31'h0, in_ready}, 32'h1);
    send(32'h5A316261, 1'b0, 2'b01);
    chk("t5_fresh_mode", out_data, 32'h5A314241);
    send(32'h5A316261, 1'b1, 2'b10);
    chk("t5_latched", out_data, 32'h5A314241);
    drain_wait();

`ifdef CASE_STATS_EN
    // 6: changed-byte counter
    send(32'h64636261, 1'b1, 2'b01);
    stat_clr = 1'b1;
    @(posedge clk);
    #1;
    stat_clr = 1'b0;
    chk("t6_clr_wins", {28'h0, conv_count}, 32'h0);
    send(32'h31634261, 1'b0, 2'b01);
    send(32'h31634261, 1'b0, 2'b01);
    send(32'h31634261, 1'b1, 2'b01);
    repeat (2) @(posedge clk);
    #1;
    chk("t6_count6", {28'h0, conv_count}, 32'd6);
    stat_clr = 1'b1;
    @(posedge clk);
    #1;
    stat_clr = 1'b0;
    chk("t6_clr", {28'h0, conv_count}, 32'h0);
    for (int i = 0; i < 5; i++) send(32'h64636261, (i == 4), 2'b01);
    repeat (2) @(posedge clk);
    #1;
    chk("t6_saturate", {28'h0, conv_count}, 32'd15);
    drain_wait();
`endif

    chk("final_queue_empty", exp_q.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
